fetch_decode_execute: RTL and testbench

3-stage in-order front end: fetch, decode and execute for a 24-bit word-addressed core. It holds the instruction ROM, PC, 16x24 register file and flags, and hands registered memory/writeback control and data to the downstream memory/writeback stages. Writeback data arrives back through dedicated input ports.

---
 rtl/fetch_decode_execute.sv | 227 ++++++++++++++++++++++
 tb/tb_fetch_decode_execute.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_execute.sv
`default_nettype none
// ============================================================================
// fetch_decode_execute : 3-stage fetch/decode/execute front end, 24-bit core.
// Optional EX/OUT-to-decode operand bypass: define FDE_BYPASS_EN.
// Revision 1.0
// ============================================================================
module fetch_decode_execute #(
   parameter int    DATA_W     = 24,
   parameter int    IMEM_DEPTH = 256,
   parameter string IMEM_FILE  = "program.hex"
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_we_in,
   input  logic [3:0]        reg_to_write_in,
   input  logic [DATA_W-1:0] wb_data,
   output logic              mem_we_out,
   output logic              reg_we_out,
   output logic              write_reg_from_alu_out,
   output logic [3:0]        reg_to_write_out,
   output logic [DATA_W-1:0] data_to_write_out,
   output logic [DATA_W-1:0] result_out,
   output logic [DATA_W-1:0] new_pc
);

   localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

   localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
                          ALU_OR  = 3'b011, ALU_SHL = 3'b100, ALU_SHR = 3'b101;
   localparam logic [2:0] BR_NONE = 3'd0, BR_JMP = 3'd1, BR_EQ = 3'd2,
                          BR_NE   = 3'd3, BR_LT  = 3'd4;

   // ROM contents are supplied by the environment (IMEM_FILE image)
   logic [DATA_W-1:0] imem [IMEM_DEPTH];
   logic [DATA_W-1:0] rf_q [16];
   logic [DATA_W-1:0] rf_d [16];

   logic [DATA_W-1:0] pc_q, pc_d, ifid_instr_q, ifid_instr_d, ifid_pc1_q, ifid_pc1_d;
   logic [2:0]        idex_alu_q, idex_alu_d, idex_br_q, idex_br_d;
   logic              idex_reg_we_q, idex_reg_we_d, idex_wfa_q, idex_wfa_d;
   logic              idex_mem_we_q, idex_mem_we_d, idex_flags_we_q, idex_flags_we_d;
   logic [DATA_W-1:0] idex_op1_q, idex_op1_d, idex_op2_q, idex_op2_d;
   logic [DATA_W-1:0] idex_rdval_q, idex_rdval_d, idex_pc1_q, idex_pc1_d;
   logic [3:0]        idex_rd_q, idex_rd_d;
   logic              z_q, z_d, n_q, n_d, c_q, c_d;
   logic              mem_we_q, mem_we_d, reg_we_q, reg_we_d, wfa_q, wfa_d;
   logic [3:0]        rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d, result_q, result_d, new_pc_q, new_pc_d;

   logic [3:0]        dec_op;
   logic [DATA_W-1:0] dec_imm, dec_op1, dec_op2;
   logic [2:0]        dec_alu, dec_br;
   logic              dec_reg_we, dec_wfa, dec_mem_we, dec_flags_we;
   logic [DATA_W:0]   ex_sum, ex_diff;
   logic [DATA_W-1:0] ex_res;
   logic              ex_carry, ex_taken;

   // Bypass from EX/OUT outranks the same-cycle writeback
   function automatic logic [DATA_W-1:0] read_reg(input logic [3:0] a);
      logic [DATA_W-1:0] v;
      v = rf_q[a];
      if (reg_we_in && reg_to_write_in == a) v = wb_data;
`ifdef FDE_BYPASS_EN
      if (reg_we_q && wfa_q && rd_q == a) v = result_q;
`endif
      return v;
   endfunction

   always_comb begin
      rf_d = rf_q;
      if (reg_we_in) rf_d[reg_to_write_in] = wb_data;
   end

   always_comb begin
      dec_op       = ifid_instr_q[23:20];
      dec_imm      = {{(DATA_W-11){1'b0}}, ifid_instr_q[10:0]};
      dec_op1      = read_reg(ifid_instr_q[14:11]);
      dec_op2      = ifid_instr_q[19] ? dec_imm : read_reg(ifid_instr_q[10:7]);
      dec_alu      = ALU_ADD;
      dec_br       = BR_NONE;
      dec_reg_we   = 1'b0;
      dec_wfa      = 1'b0;
      dec_mem_we   = 1'b0;
      dec_flags_we = 1'b0;
      case (dec_op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
            dec_alu    = dec_op[2:0] - 3'd1;
            dec_reg_we = 1'b1;
            dec_wfa    = 1'b1;
         end
         4'h7: begin
            dec_alu      = ALU_SUB;
            dec_flags_we = 1'b1;
         end
         4'h8: begin
            dec_op2    = dec_imm;
            dec_reg_we = 1'b1;
         end
         4'h9: begin
            dec_op2    = dec_imm;
            dec_mem_we = 1'b1;
         end
         4'hA, 4'hB, 4'hC, 4'hD: begin
            // Zero op1 so the add path yields the target itself
            dec_op1 = '0;
            dec_op2 = dec_imm;
            dec_br  = dec_op[2:0] - 3'd1;
         end
         default: ;
      endcase
   end

   always_comb begin
      ex_sum   = {1'b0, idex_op1_q} + {1'b0, idex_op2_q};
      ex_diff  = {1'b0, idex_op1_q} - {1'b0, idex_op2_q};
      ex_res   = ex_sum[DATA_W-1:0];
      ex_carry = ex_sum[DATA_W];
      case (idex_alu_q)
         ALU_SUB: begin ex_res = ex_diff[DATA_W-1:0]; ex_carry = ex_diff[DATA_W]; end
         ALU_AND: begin ex_res = idex_op1_q & idex_op2_q; ex_carry = 1'b0; end
         ALU_OR:  begin ex_res = idex_op1_q | idex_op2_q; ex_carry = 1'b0; end
         ALU_SHL: begin ex_res = idex_op1_q << idex_op2_q[4:0]; ex_carry = 1'b0; end
         ALU_SHR: begin ex_res = idex_op1_q >> idex_op2_q[4:0]; ex_carry = 1'b0; end
         default: ;
      endcase
      case (idex_br_q)
         BR_JMP:  ex_taken = 1'b1;
         BR_EQ:   ex_taken = z_q;
         BR_NE:   ex_taken = ~z_q;
         BR_LT:   ex_taken = n_q;
         default: ex_taken = 1'b0;
      endcase
   end

   always_comb begin
      pc_d            = ex_taken ? idex_op2_q : pc_q + 1'b1;
      ifid_instr_d    = ex_taken ? '0 : imem[pc_q[AW-1:0]];
      ifid_pc1_d      = ex_taken ? '0 : pc_q + 1'b1;
      idex_alu_d      = ex_taken ? ALU_ADD : dec_alu;
      idex_br_d       = ex_taken ? BR_NONE : dec_br;
      idex_reg_we_d   = ~ex_taken & dec_reg_we;
      idex_wfa_d      = ~ex_taken & dec_wfa;
      idex_mem_we_d   = ~ex_taken & dec_mem_we;
      idex_flags_we_d = ~ex_taken & dec_flags_we;
      idex_op1_d      = ex_taken ? '0 : dec_op1;
      idex_op2_d      = ex_taken ? '0 : dec_op2;
      idex_rdval_d    = ex_taken ? '0 : read_reg(ifid_instr_q[18:15]);
      idex_rd_d       = ex_taken ? '0 : ifid_instr_q[18:15];
      idex_pc1_d      = ex_taken ? '0 : ifid_pc1_q;
      z_d             = idex_flags_we_q ? (ex_res == '0) : z_q;
      n_d             = idex_flags_we_q ? ex_res[DATA_W-1] : n_q;
      c_d             = idex_flags_we_q ? ex_carry : c_q;
      mem_we_d        = idex_mem_we_q;
      reg_we_d        = idex_reg_we_q;
      wfa_d           = idex_wfa_q;
      rd_d            = idex_rd_q;
      data_d          = idex_rdval_q;
      result_d        = ex_res;
      new_pc_d        = ex_taken ? idex_op2_q : idex_pc1_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_q            <= '{default: '0};
         pc_q            <= '0;
         ifid_instr_q    <= '0;
         ifid_pc1_q      <= '0;
         idex_alu_q      <= ALU_ADD;
         idex_br_q       <= BR_NONE;
         idex_reg_we_q   <= 1'b0;
         idex_wfa_q      <= 1'b0;
         idex_mem_we_q   <= 1'b0;
         idex_flags_we_q <= 1'b0;
         idex_op1_q      <= '0;
         idex_op2_q      <= '0;
         idex_rdval_q    <= '0;
         idex_rd_q       <= '0;
         idex_pc1_q      <= '0;
         z_q             <= 1'b0;
         n_q             <= 1'b0;
         c_q             <= 1'b0;
         mem_we_q        <= 1'b0;
         reg_we_q        <= 1'b0;
         wfa_q           <= 1'b0;
         rd_q            <= '0;
         data_q          <= '0;
         result_q        <= '0;
         new_pc_q        <= '0;
      end else begin
         rf_q            <= rf_d;
         pc_q            <= pc_d;
         ifid_instr_q    <= ifid_instr_d;
         ifid_pc1_q      <= ifid_pc1_d;
         idex_alu_q      <= idex_alu_d;
         idex_br_q       <= idex_br_d;
         idex_reg_we_q   <= idex_reg_we_d;
         idex_wfa_q      <= idex_wfa_d;
         idex_mem_we_q   <= idex_mem_we_d;
         idex_flags_we_q <= idex_flags_we_d;
         idex_op1_q      <= idex_op1_d;
         idex_op2_q      <= idex_op2_d;
         idex_rdval_q    <= idex_rdval_d;
         idex_rd_q       <= idex_rd_d;
         idex_pc1_q      <= idex_pc1_d;
         z_q             <= z_d;
         n_q             <= n_d;
         c_q             <= c_d;
         mem_we_q        <= mem_we_d;
         reg_we_q        <= reg_we_d;
         wfa_q           <= wfa_d;
         rd_q            <= rd_d;
         data_q          <= data_d;
         result_q        <= result_d;
         new_pc_q        <= new_pc_d;
      end
   end

   assign mem_we_out             = mem_we_q;
   assign reg_we_out             = reg_we_q;
   assign write_reg_from_alu_out = wfa_q;
   assign reg_to_write_out       = rd_q;
   assign data_to_write_out      = data_q;
   assign result_out             = result_q;
   assign new_pc                 = new_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_execute.sv
`default_nettype none
// ============================================================================
// tb_fetch_decode_execute : scoreboard bench; acts as the memory/writeback stage.
// Revision 1.0
// ============================================================================
module tb_fetch_decode_execute;

   localparam logic [23:0] LOAD_VAL = 24'h000042;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        reg_we_in = 1'b0;
   logic [3:0]  reg_to_write_in = 4'd0;
   logic [23:0] wb_data = 24'd0;
   logic        mem_we_out, reg_we_out, write_reg_from_alu_out;
   logic [3:0]  reg_to_write_out;
   logic [23:0] data_to_write_out, result_out, new_pc;

   fetch_decode_execute dut (
      .clk                    (clk),
      .reset                  (reset),
      .reg_we_in              (reg_we_in),
      .reg_to_write_in        (reg_to_write_in),
      .wb_data                (wb_data),
      .mem_we_out             (mem_we_out),
      .reg_we_out             (reg_we_out),
      .write_reg_from_alu_out (write_reg_from_alu_out),
      .reg_to_write_out       (reg_to_write_out),
      .data_to_write_out      (data_to_write_out),
      .result_out             (result_out),
      .new_pc                 (new_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        mem_we;
      logic        reg_we;
      logic        wfa;
      logic [3:0]  rd;
      logic [23:0] data;
      logic [23:0] res;
      logic [23:0] npc;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic        ovr = 1'b0;
   logic        ovr_we = 1'b0;
   logic [3:0]  ovr_rd = 4'd0;
   logic [23:0] ovr_data = 24'd0;
   logic [23:0] exp_byp;

   task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] enc_i(input logic [3:0] op, input logic [3:0] rd,
                                         input logic [3:0] rs, input logic [10:0] imm);
      return {op, 1'b1, rd, rs, imm};
   endfunction

   task automatic exp_push(input logic m, input logic r, input logic w, input logic [3:0] rd,
                           input logic [23:0] d, input logic [23:0] res, input logic [23:0] npc);
      exp_t e;
      e = '{m, r, w, rd, d, res, npc};
      sb.push_back(e);
   endtask

   task automatic exp_zero(input int n);
      for (int i = 0; i < n; i++) exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 24'd0);
   endtask

   task automatic exp_nop(input logic [23:0] npc);
      exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, npc);
   endtask

   // One clock: compare the popped expectation, then write back like the downstream stage
   task automatic tick(input string tag, input int n);
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s e%0d: scoreboard empty, got res %h expected an entry", tag, n, result_out);
      end else begin
         e = sb.pop_front();
         check($sformatf("%s e%0d mem_we", tag, n), 24'(mem_we_out), 24'(e.mem_we));
         check($sformatf("%s e%0d reg_we", tag, n), 24'(reg_we_out), 24'(e.reg_we));
         check($sformatf("%s e%0d wfa", tag, n), 24'(write_reg_from_alu_out), 24'(e.wfa));
         check($sformatf("%s e%0d rd", tag, n), 24'(reg_to_write_out), 24'(e.rd));
         check($sformatf("%s e%0d data", tag, n), data_to_write_out, e.data);
         check($sformatf("%s e%0d result", tag, n), result_out, e.res);
         check($sformatf("%s e%0d new_pc", tag, n), new_pc, e.npc);
      end
      if (ovr) begin
         reg_we_in       = ovr_we;
         reg_to_write_in = ovr_rd;
         wb_data         = ovr_data;
         ovr             = 1'b0;
      end else begin
         reg_we_in       = reg_we_out;
         reg_to_write_in = reg_to_write_out;
         wb_data         = write_reg_from_alu_out ? result_out : LOAD_VAL;
      end
   endtask

   task automatic start_reset();
      reset           = 1'b1;
      reg_we_in       = 1'b0;
      reg_to_write_in = 4'd0;
      wb_data         = 24'd0;
      for (int i = 0; i < 256; i++) dut.imem[i] = 24'd0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " mem_we"}, 24'(mem_we_out), 24'd0);
      check({tag, " reg_we"}, 24'(reg_we_out), 24'd0);
      check({tag, " wfa"}, 24'(write_reg_from_alu_out), 24'd0);
      check({tag, " rd"}, 24'(reg_to_write_out), 24'd0);
      check({tag, " data"}, data_to_write_out, 24'd0);
      check({tag, " result"}, result_out, 24'd0);
      check({tag, " new_pc"}, new_pc, 24'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Program A: ALU, JMP with flush, ST, LD
      start_reset();
      dut.imem[0]  = enc_i(4'h1, 4'd2, 4'd0, 11'd1);
      dut.imem[1]  = enc_i(4'hA, 4'd0, 4'd0, 11'd7);
      dut.imem[2]  = enc_i(4'h1, 4'd9, 4'd0, 11'd99);
      dut.imem[3]  = enc_i(4'h1, 4'd9, 4'd0, 11'd98);
      dut.imem[7]  = enc_i(4'h1, 4'd5, 4'd2, 11'd3);
      dut.imem[9]  = enc_i(4'h9, 4'd5, 4'd0, 11'd3);
      dut.imem[10] = enc_i(4'h8, 4'd7, 4'd8, 11'd2);
      dut.imem[12] = enc_i(4'h1, 4'd6, 4'd7, 11'd0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      exp_zero(2);
      exp_push(1'b0, 1'b1, 1'b1, 4'd2, 24'd0, 24'd1, 24'd1);
      exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd7, 24'd7);
      exp_zero(2);
      exp_push(1'b0, 1'b1, 1'b1, 4'd5, 24'd0, 24'd4, 24'd8);
      exp_nop(24'd9);
      exp_push(1'b1, 1'b0, 1'b0, 4'd5, 24'd4, 24'd3, 24'd10);
      exp_push(1'b0, 1'b1, 1'b0, 4'd7, 24'd0, 24'd2, 24'd11);
      exp_nop(24'd12);
      exp_push(1'b0, 1'b1, 1'b1, 4'd6, 24'd0, LOAD_VAL, 24'd13);
      release_reset();
      for (int i = 1; i <= 12; i++) tick("A", i);

      // Asynchronous reset mid-cycle, then restart from ROM[0]
      #3;
      reset     = 1'b1;
      reg_we_in = 1'b0;
      #1;
      check_outputs_zero("async_reset");
      @(posedge clk);
      #2;
      reset = 1'b0;
      exp_zero(2);
      exp_push(1'b0, 1'b1, 1'b1, 4'd2, 24'd0, 24'd1, 24'd1);
      exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd7, 24'd7);
      exp_zero(2);
      exp_push(1'b0, 1'b1, 1'b1, 4'd5, 24'd0, 24'd4, 24'd8);
      for (int i = 1; i <= 7; i++) tick("A_restart", i);

      // Program B: CMP + conditional branches, taken and not taken
      start_reset();
      dut.imem[0]  = enc_i(4'h1, 4'd3, 4'd0, 11'd5);
      dut.imem[3]  = enc_i(4'h7, 4'd0, 4'd3, 11'd5);
      dut.imem[4]  = enc_i(4'hB, 4'd0, 4'd0, 11'd20);
      dut.imem[5]  = enc_i(4'h1, 4'd9, 4'd0, 11'd1);
      dut.imem[6]  = enc_i(4'h1, 4'd9, 4'd0, 11'd2);
      dut.imem[20] = enc_i(4'h7, 4'd0, 4'd3, 11'd6);
      dut.imem[21] = enc_i(4'hB, 4'd0, 4'd0, 11'd40);
      dut.imem[22] = enc_i(4'hD, 4'd0, 4'd0, 11'd50);
      dut.imem[23] = enc_i(4'h1, 4'd9, 4'd0, 11'd3);
      dut.imem[24] = enc_i(4'h1, 4'd9, 4'd0, 11'd4);
      exp_zero(2);
      exp_push(1'b0, 1'b1, 1'b1, 4'd3, 24'd0, 24'd5, 24'd1);
      exp_nop(24'd2);
      exp_nop(24'd3);
      exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd0, 24'd4);
      exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd20, 24'd20);
      exp_zero(2);
      exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'hFFFFFF, 24'd21);
      exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd40, 24'd22);
      exp_push(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 24'd50, 24'd50);
      exp_zero(2);
      exp_nop(24'd51);
      release_reset();
      for (int i = 1; i <= 15; i++) tick("B", i);

      // Program C: write-through, then operand path with writeback withheld
      start_reset();
      dut.imem[0] = enc_i(4'h1, 4'd4, 4'd3, 11'd0);
      dut.imem[1] = enc_i(4'h1, 4'd1, 4'd0, 11'd4);
      dut.imem[3] = enc_i(4'h1, 4'd2, 4'd1, 11'd1);
`ifdef FDE_BYPASS_EN
      exp_byp = 24'd5;
`else
      exp_byp = 24'd1;
`endif
      exp_zero(2);
      exp_push(1'b0, 1'b1, 1'b1, 4'd4, 24'd0, 24'h00ABCD, 24'd1);
      exp_push(1'b0, 1'b1, 1'b1, 4'd1, 24'd0, 24'd4, 24'd2);
      exp_nop(24'd3);
      exp_push(1'b0, 1'b1, 1'b1, 4'd2, 24'd0, exp_byp, 24'd4);
      release_reset();
      ovr      = 1'b1;
      ovr_we   = 1'b1;
      ovr_rd   = 4'd3;
      ovr_data = 24'h00ABCD;
      for (int i = 1; i <= 3; i++) tick("C", i);
      ovr      = 1'b1;
      ovr_we   = 1'b0;
      ovr_rd   = 4'd0;
      ovr_data = 24'd0;
      for (int i = 4; i <= 6; i++) tick("C", i);

      check("sb_drain", 24'(sb.size()), 24'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
